// File: rtl/stg4ma_pkg.sv
// Shared sizes, opcodes and the stage-4 output bundle for the diad memory-access stage.
package stg4ma_pkg;

  localparam int unsigned SIZE_ADDR   = 24;
  localparam int unsigned SIZE_DATA   = 24;
  localparam int unsigned SIZE_OPC    = 6;
  localparam int unsigned SIZE_TGT_GP = 4;
  localparam int unsigned SIZE_TGT_SR = 2;

  localparam logic [SIZE_OPC-1:0] OPC_NOP   = 6'h00;
  localparam logic [SIZE_OPC-1:0] OPC_A_ADD = 6'h01;
  localparam logic [SIZE_OPC-1:0] OPC_M_LD  = 6'h10;
  localparam logic [SIZE_OPC-1:0] OPC_M_ST  = 6'h11;

  typedef struct packed {
    logic [SIZE_ADDR-1:0]   pc;
    logic [SIZE_DATA-1:0]   instr;
    logic [SIZE_OPC-1:0]    opc;
    logic [SIZE_TGT_GP-1:0] tgt_gp;
    logic [SIZE_TGT_SR-1:0] tgt_sr;
    logic [SIZE_DATA-1:0]   result;
  } stage_t;

  function automatic logic is_mem_opc(input logic [SIZE_OPC-1:0] opc);
    return (opc == OPC_M_LD) || (opc == OPC_M_ST);
  endfunction

endpackage

// File: rtl/stg4ma.sv
// Pipeline stage 4 (memory access): registers ALU results toward writeback and runs a
// req/ack data-memory transaction for LD/ST, stalling upstream until it completes or times out.
module stg4ma
  import stg4ma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst_n,
  input  logic [SIZE_ADDR-1:0]   iw_pc,
  input  logic [SIZE_DATA-1:0]   iw_instr,
  input  logic [SIZE_OPC-1:0]    iw_opc,
  input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic [SIZE_DATA-1:0]   iw_result,
  input  logic [SIZE_DATA-1:0]   iw_src_data,
  output logic                   ow_stall,
  output logic                   ow_mem_req,
  output logic                   ow_mem_we,
  output logic [SIZE_ADDR-1:0]   ow_mem_addr,
  output logic [SIZE_DATA-1:0]   ow_mem_wdata,
  input  logic                   iw_mem_ack,
  input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
  output logic [SIZE_ADDR-1:0]   ow_pc,
  output logic [SIZE_DATA-1:0]   ow_instr,
  output logic [SIZE_OPC-1:0]    ow_opc,
  output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
  output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
  output logic [SIZE_DATA-1:0]   ow_result,
  output logic                   ow_mem_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d;
  logic [SIZE_DATA-1:0] wdata_q, wdata_d;
  stage_t               out_q, out_d;
  stage_t               cur;

  always_comb begin
    cur = '{pc: iw_pc, instr: iw_instr, opc: iw_opc, tgt_gp: iw_tgt_gp,
            tgt_sr: iw_tgt_sr, result: iw_result};
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    out_d    = '0;  // bubble: OPC_NOP with every field zero
    ow_stall = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_mem_opc(iw_opc)) begin
          ow_stall = 1'b1;
          addr_d   = iw_result[SIZE_ADDR-1:0];
          wdata_d  = iw_src_data;
          we_d     = (iw_opc == OPC_M_ST);
          req_d    = 1'b1;
          cnt_d    = '0;
          state_d  = StWait;
        end else begin
          out_d = cur;
        end
      end
      StWait: begin
        ow_stall = ~iw_mem_ack;
        // Ack takes priority over a timeout landing in the same cycle.
        if (iw_mem_ack) begin
          out_d = cur;
          if (!we_q) out_d.result = iw_mem_rdata;
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          out_d        = cur;
          out_d.result = '0;
          req_d        = 1'b0;
          err_d        = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
    end
  end

  assign ow_mem_req   = req_q;
  assign ow_mem_we    = we_q;
  assign ow_mem_addr  = addr_q;
  assign ow_mem_wdata = wdata_q;
  assign ow_mem_err   = err_q;
  assign ow_pc        = out_q.pc;
  assign ow_instr     = out_q.instr;
  assign ow_opc       = out_q.opc;
  assign ow_tgt_gp    = out_q.tgt_gp;
  assign ow_tgt_sr    = out_q.tgt_sr;
  assign ow_result    = out_q.result;

endmodule

// File: tb/tb_stg4ma.sv
// Directed self-checking bench for stg4ma: pass-through, load, store, timeout, reset, stray ack.
module tb_stg4ma;
  import stg4ma_pkg::*;

  logic                   iw_clk = 1'b0;
  logic                   iw_rst_n;
  logic [SIZE_ADDR-1:0]   iw_pc;
  logic [SIZE_DATA-1:0]   iw_instr;
  logic [SIZE_OPC-1:0]    iw_opc;
  logic [SIZE_TGT_GP-1:0] iw_tgt_gp;
  logic [SIZE_TGT_SR-1:0] iw_tgt_sr;
  logic [SIZE_DATA-1:0]   iw_result;
  logic [SIZE_DATA-1:0]   iw_src_data;
  logic                   ow_stall;
  logic                   ow_mem_req;
  logic                   ow_mem_we;
  logic [SIZE_ADDR-1:0]   ow_mem_addr;
  logic [SIZE_DATA-1:0]   ow_mem_wdata;
  logic                   iw_mem_ack;
  logic [SIZE_DATA-1:0]   iw_mem_rdata;
  logic [SIZE_ADDR-1:0]   ow_pc;
  logic [SIZE_DATA-1:0]   ow_instr;
  logic [SIZE_OPC-1:0]    ow_opc;
  logic [SIZE_TGT_GP-1:0] ow_tgt_gp;
  logic [SIZE_TGT_SR-1:0] ow_tgt_sr;
  logic [SIZE_DATA-1:0]   ow_result;
  logic                   ow_mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 iw_clk = ~iw_clk;

  stg4ma #(.TIMEOUT_CYCLES(15)) dut (
    .iw_clk       (iw_clk),
    .iw_rst_n     (iw_rst_n),
    .iw_pc        (iw_pc),
    .iw_instr     (iw_instr),
    .iw_opc       (iw_opc),
    .iw_tgt_gp    (iw_tgt_gp),
    .iw_tgt_sr    (iw_tgt_sr),
    .iw_result    (iw_result),
    .iw_src_data  (iw_src_data),
    .ow_stall     (ow_stall),
    .ow_mem_req   (ow_mem_req),
    .ow_mem_we    (ow_mem_we),
    .ow_mem_addr  (ow_mem_addr),
    .ow_mem_wdata (ow_mem_wdata),
    .iw_mem_ack   (iw_mem_ack),
    .iw_mem_rdata (iw_mem_rdata),
    .ow_pc        (ow_pc),
    .ow_instr     (ow_instr),
    .ow_opc       (ow_opc),
    .ow_tgt_gp    (ow_tgt_gp),
    .ow_tgt_sr    (ow_tgt_sr),
    .ow_result    (ow_result),
    .ow_mem_err   (ow_mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] pc, input logic [5:0] opc, input logic [3:0] gp,
                       input logic [23:0] res, input logic [23:0] src);
    iw_pc       = pc;
    iw_instr    = {pc[11:0], 12'hA5A};
    iw_opc      = opc;
    iw_tgt_gp   = gp;
    iw_tgt_sr   = 2'd1;
    iw_result   = res;
    iw_src_data = src;
    #1;
  endtask

  initial begin
    iw_rst_n     = 1'b0;
    iw_mem_ack   = 1'b0;
    iw_mem_rdata = '0;
    drive(24'h0, OPC_NOP, 4'd0, 24'h0, 24'h0);
    tick();
    tick();
    check("rst_opc", 32'(ow_opc), 32'(OPC_NOP));
    check("rst_result", 32'(ow_result), 32'h0);
    check("rst_req", 32'(ow_mem_req), 32'h0);
    check("rst_err", 32'(ow_mem_err), 32'h0);
    check("rst_stall", 32'(ow_stall), 32'h0);
    iw_rst_n = 1'b1;
    tick();

    // ALU pass-through
    drive(24'h000001, OPC_A_ADD, 4'd3, 24'h000123, 24'h0);
    check("add_stall", 32'(ow_stall), 32'h0);
    tick();
    check("add_opc", 32'(ow_opc), 32'(OPC_A_ADD));
    check("add_result", 32'(ow_result), 32'h000123);
    check("add_gp", 32'(ow_tgt_gp), 32'd3);
    check("add_pc", 32'(ow_pc), 32'h000001);
    check("add_sr", 32'(ow_tgt_sr), 32'd1);

    // Load acked in the first request cycle
    drive(24'h000002, OPC_M_LD, 4'd5, 24'h000010, 24'h0);
    check("ld_stall_idle", 32'(ow_stall), 32'h1);
    check("ld_req_idle", 32'(ow_mem_req), 32'h0);
    tick();
    check("ld_req", 32'(ow_mem_req), 32'h1);
    check("ld_we", 32'(ow_mem_we), 32'h0);
    check("ld_addr", 32'(ow_mem_addr), 32'h000010);
    check("ld_bubble", 32'(ow_opc), 32'(OPC_NOP));
    check("ld_bubble_pc", 32'(ow_pc), 32'h0);
    iw_mem_ack   = 1'b1;
    iw_mem_rdata = 24'h00ABCD;
    #1;
    check("ld_stall_ack", 32'(ow_stall), 32'h0);
    tick();
    iw_mem_ack = 1'b0;
    check("ld_opc", 32'(ow_opc), 32'(OPC_M_LD));
    check("ld_result", 32'(ow_result), 32'h00ABCD);
    check("ld_gp", 32'(ow_tgt_gp), 32'd5);
    check("ld_req_done", 32'(ow_mem_req), 32'h0);

    // Store with four request cycles
    drive(24'h000003, OPC_M_ST, 4'd0, 24'h000020, 24'h00005A);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) iw_mem_ack = 1'b1;
      iw_mem_rdata = 24'hFFFFFF;
      #1;
      check("st_req", 32'(ow_mem_req), 32'h1);
      check("st_we", 32'(ow_mem_we), 32'h1);
      check("st_wdata", 32'(ow_mem_wdata), 32'h00005A);
      check("st_addr", 32'(ow_mem_addr), 32'h000020);
      check("st_stall", 32'(ow_stall), (i == 3) ? 32'h0 : 32'h1);
      tick();
    end
    iw_mem_ack = 1'b0;
    check("st_opc", 32'(ow_opc), 32'(OPC_M_ST));
    check("st_result", 32'(ow_result), 32'h000020);

    // Load that never gets acked
    drive(24'h000004, OPC_M_LD, 4'd7, 24'h000030, 24'h0);
    tick();
    for (int i = 0; i < 15; i++) begin
      check("to_req", 32'(ow_mem_req), 32'h1);
      check("to_err_pend", 32'(ow_mem_err), 32'h0);
      tick();
    end
    check("to_req_drop", 32'(ow_mem_req), 32'h0);
    check("to_err", 32'(ow_mem_err), 32'h1);
    check("to_opc", 32'(ow_opc), 32'(OPC_M_LD));
    check("to_result", 32'(ow_result), 32'h0);
    drive(24'h000005, OPC_A_ADD, 4'd2, 24'h000077, 24'h0);
    check("to_add_stall", 32'(ow_stall), 32'h0);
    tick();
    check("to_add_opc", 32'(ow_opc), 32'(OPC_A_ADD));
    check("to_add_result", 32'(ow_result), 32'h000077);
    check("to_err_sticky", 32'(ow_mem_err), 32'h1);

    // Stray ack while idle
    drive(24'h000006, OPC_A_ADD, 4'd1, 24'h000055, 24'h0);
    iw_mem_ack   = 1'b1;
    iw_mem_rdata = 24'h123456;
    #1;
    check("spur_stall", 32'(ow_stall), 32'h0);
    tick();
    iw_mem_ack = 1'b0;
    check("spur_result", 32'(ow_result), 32'h000055);
    check("spur_req", 32'(ow_mem_req), 32'h0);

    // Reset on the third request cycle
    drive(24'h000007, OPC_M_LD, 4'd4, 24'h000040, 24'h0);
    tick();
    tick();
    tick();
    check("rw_req", 32'(ow_mem_req), 32'h1);
    iw_rst_n = 1'b0;
    tick();
    check("rw_req_off", 32'(ow_mem_req), 32'h0);
    check("rw_opc", 32'(ow_opc), 32'(OPC_NOP));
    check("rw_pc", 32'(ow_pc), 32'h0);
    check("rw_err", 32'(ow_mem_err), 32'h0);
    check("rw_addr", 32'(ow_mem_addr), 32'h0);
    check("rw_stall_ld", 32'(ow_stall), 32'h1);
    iw_rst_n = 1'b1;
    drive(24'h0, OPC_NOP, 4'd0, 24'h0, 24'h0);
    tick();
    check("rw_no_retire", 32'(ow_opc), 32'(OPC_NOP));
    check("rw_idle_req", 32'(ow_mem_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
